// File: rtl/seq_ser_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_ser_tx : valid/ready parallel-to-serial transmitter, MSB first,     |
// | one-word holding buffer, optional preamble via SEQ_SER_TX_PREAMBLE_EN.  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module seq_ser_tx #(
  parameter int                DATA_W     = 8,
  parameter int                BIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] PREAMBLE   = 8'b10011001,
  parameter logic              IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_data,
  output logic              ser_en,
  output logic              busy,
  output logic              frame_done
);

`ifdef SEQ_SER_TX_PREAMBLE_EN
  localparam int FRAME_BITS = 2 * DATA_W;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd2;
`ifdef SEQ_SER_TX_PREAMBLE_EN
  localparam logic [1:0] S_PRE       = 2'd1;
  localparam logic [1:0] S_FIRST     = S_PRE;
  localparam logic [BIT_W-1:0] BIT_PRE_LAST = BIT_W'(DATA_W - 1);
`else
  localparam logic [1:0] S_FIRST     = S_DATA;
`endif

  logic [1:0]            state_q, state_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic                  ser_data_q, ser_data_d;
  logic                  ser_en_q, ser_en_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  accept;
  logic                  load;
  logic                  frame_end;
  logic                  bit_wrap;
  logic [FRAME_BITS-1:0] frame_word;

  // The preamble and data word share one wide shifter, so the data word
  // reaches the MSB exactly as the preamble's last bit shifts out.
`ifdef SEQ_SER_TX_PREAMBLE_EN
  assign frame_word = {PREAMBLE, hold_q};
`else
  logic unused_preamble;
  assign unused_preamble = ^PREAMBLE;
  assign frame_word      = hold_q;
`endif

  assign tx_ready    = rst && !hold_full_q;
  assign accept      = tx_valid && tx_ready;
  assign hold_d      = accept ? tx_data : hold_q;
  assign hold_full_d = accept || (hold_full_q && !load);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      bit_q        <= '0;
      cyc_q        <= '0;
      ser_data_q   <= IDLE_LEVEL;
      ser_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      cyc_q        <= cyc_d;
      ser_data_q   <= ser_data_d;
      ser_en_q     <= ser_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    cyc_d     = cyc_q;
    load      = 1'b0;
    frame_end = 1'b0;
    bit_wrap  = (cyc_q == CYC_LAST);
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      default: begin
        if (bit_wrap) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            frame_end = 1'b1;
            bit_d     = '0;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_d   = bit_q + 1'b1;
`ifdef SEQ_SER_TX_PREAMBLE_EN
            if ((state_q == S_PRE) && (bit_q == BIT_PRE_LAST)) begin
              state_d = S_DATA;
            end
`endif
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
    endcase
    if (load) begin
      shift_d = frame_word;
      state_d = S_FIRST;
      bit_d   = '0;
      cyc_d   = '0;
    end
  end

  always_comb begin
    ser_en_d     = (state_d != S_IDLE);
    ser_data_d   = ser_en_d ? shift_d[FRAME_BITS-1] : IDLE_LEVEL;
    busy_d       = ser_en_d || hold_full_d;
    frame_done_d = frame_end;
  end

  assign ser_data   = ser_data_q;
  assign ser_en     = ser_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_ser_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_seq_ser_tx : scoreboard bench, one instance at 1 cycle/bit and one   |
// | at 3 cycles/bit. Rev 1.0                                                |
// +------------------------------------------------------------------------+
module tb_seq_ser_tx;
  localparam int DATA_W = 8;
`ifdef SEQ_SER_TX_PREAMBLE_EN
  localparam int FRAME_BITS = 2 * DATA_W;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam logic [DATA_W-1:0] PRE_WORD = 8'b10011001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, sd_a, en_a, busy_a, fd_a;
  logic       ready_b, sd_b, en_b, busy_b, fd_b;

  seq_ser_tx #(.DATA_W(8), .BIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .ser_data(sd_a), .ser_en(en_a), .busy(busy_a),
    .frame_done(fd_a));

  seq_ser_tx #(.DATA_W(8), .BIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .ser_data(sd_b), .ser_en(en_b), .busy(busy_b),
    .frame_done(fd_b));

  // Scoreboard entries: {last bit of frame, expected serial bit}
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic       fdp_a = 1'b0, fdp_b = 1'b0;
  logic       last_acc_a = 1'b0, last_acc_b = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int id, input logic [7:0] w);
    logic [FRAME_BITS-1:0] f;
    logic [1:0]            e;
    int                    bc;
    bc = (id == 0) ? 1 : 3;
`ifdef SEQ_SER_TX_PREAMBLE_EN
    f = {PRE_WORD, w};
`else
    f = w;
`endif
    for (int i = FRAME_BITS - 1; i >= 0; i--) begin
      for (int r = 0; r < bc; r++) begin
        e = {(i == 0) && (r == bc - 1), f[i]};
        if (id == 0) q_a.push_back(e); else q_b.push_back(e);
      end
    end
  endtask

  task automatic sample_one(input int id, input logic sd, input logic en,
                            input logic bz, input logic fd, input logic acc,
                            input logic [7:0] w);
    string      nm;
    int         sz;
    int         sz2;
    logic [1:0] e;
    logic       nf;
    nm = (id == 0) ? "a" : "b";
    sz = (id == 0) ? q_a.size() : q_b.size();
    chk({nm, "_frame_done"}, fd, (id == 0) ? fdp_a : fdp_b);
    chk({nm, "_ser_en"}, en, sz != 0);
    nf = 1'b0;
    if (sz != 0) begin
      if (id == 0) e = q_a.pop_front(); else e = q_b.pop_front();
      chk({nm, "_ser_data"}, sd, e[0]);
      nf = e[1];
    end else begin
      chk({nm, "_idle_level"}, sd, 1'b0);
    end
    if (acc) push_word(id, w);
    sz2 = (id == 0) ? q_a.size() : q_b.size();
    chk({nm, "_busy"}, bz, (sz != 0) || (sz2 != 0));
    if (id == 0) fdp_a = nf; else fdp_b = nf;
  endtask

  // One clock: latch handshakes seen before the edge, then sample at negedge.
  task automatic cycle();
    logic       aa, ab;
    logic [7:0] wa, wb;
    aa = valid_a && ready_a;
    ab = valid_b && ready_b;
    wa = data_a;
    wb = data_b;
    @(posedge clk);
    @(negedge clk);
    last_acc_a = aa;
    last_acc_b = ab;
    sample_one(0, sd_a, en_a, busy_a, fd_a, aa, wa);
    sample_one(1, sd_b, en_b, busy_b, fd_b, ab, wb);
  endtask

  task automatic send_a(input logic [7:0] w, input logic keep);
    data_a  = w;
    valid_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (last_acc_a) break;
    end
    chk("a_accept_timeout", last_acc_a, 1'b1);
    if (!keep) valid_a = 1'b0;
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_a_ser_en"}, en_a, 1'b0);
    chk({tag, "_a_ser_data"}, sd_a, 1'b0);
    chk({tag, "_a_busy"}, busy_a, 1'b0);
    chk({tag, "_a_frame_done"}, fd_a, 1'b0);
    chk({tag, "_a_tx_ready"}, ready_a, 1'b0);
    chk({tag, "_b_ser_en"}, en_b, 1'b0);
    chk({tag, "_b_tx_ready"}, ready_b, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset_outputs_check("reset");
    rst = 1'b1;
    #1;
    chk("release_a_tx_ready", ready_a, 1'b1);
    chk("release_b_tx_ready", ready_b, 1'b1);
    repeat (2) cycle();

    // Single word 0x99
    send_a(8'h99, 1'b0);
    repeat (FRAME_BITS + 3) cycle();

    // Back-to-back 0xA5 then 0x3C with valid held high
    send_a(8'hA5, 1'b1);
    send_a(8'h3C, 1'b0);
    chk("b2b_ready_low_0", ready_a, 1'b0);
    for (int i = 1; i < FRAME_BITS - 1; i++) begin
      cycle();
      chk("b2b_ready_low", ready_a, 1'b0);
    end
    cycle();
    chk("b2b_ready_after_load", ready_a, 1'b1);
    repeat (FRAME_BITS + 3) cycle();

    // Slow instance: 0x81 at 3 cycles per bit
    data_b  = 8'h81;
    valid_b = 1'b1;
    cycle();
    chk("b_accept", last_acc_b, 1'b1);
    valid_b = 1'b0;
    repeat (FRAME_BITS * 3 + 4) cycle();

    // Valid pulse while the holding register is full is ignored
    send_a(8'h11, 1'b0);
    send_a(8'h22, 1'b0);
    chk("full_ready_low", ready_a, 1'b0);
    data_a  = 8'h77;
    valid_a = 1'b1;
    cycle();
    valid_a = 1'b0;
    repeat (2 * FRAME_BITS + 4) cycle();

    // Reset mid-frame with a second word held
    send_a(8'hFF, 1'b0);
    send_a(8'h0F, 1'b0);
    repeat (2) cycle();
    chk("pre_reset_active", en_a, 1'b1);
    rst = 1'b0;
    #1;
    reset_outputs_check("midreset");
    q_a.delete();
    q_b.delete();
    fdp_a = 1'b0;
    fdp_b = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    chk("post_reset_tx_ready", ready_a, 1'b1);
    repeat (2 * FRAME_BITS + 4) cycle();

    // Final word after reset to show normal operation resumes
    send_a(8'h5A, 1'b0);
    repeat (FRAME_BITS + 3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
